featuremap_pad_writer: RTL and testbench

FEATUREMAP_PAD_WRITER -- requirements
Module: featuremap_pad_writer

---
 rtl/featuremap_pad_writer.sv | 77 +++++++
 tb/tb_featuremap_pad_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/featuremap_pad_writer.sv
// Streams one zero-padded (WIDTH+2)x(WIDTH+2) feature-map frame into the conv2D feed FIFO,
// reading interior words from an upstream show-ahead FIFO and inserting PAD_VALUE on the border.
module featuremap_pad_writer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    WIDTH      = 56,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_fifo_empty,
    output logic                  rdreq,
    input  logic                  fifo_full,
    output logic                  wrreq,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int            CW   = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          border;
    logic          in_run;

    // Accept is zero-latency: the write/pop decision is made from the current position and
    // the two FIFO flags in the same cycle, so a stalled position simply repeats.
    always_comb begin
        in_run   = (state == S_RUN);
        border   = (row == '0) || (row == LAST) || (col == '0) || (col == LAST);
        wrreq    = in_run && !fifo_full && (border || !data_fifo_empty);
        rdreq    = in_run && !fifo_full && !border && !data_fifo_empty;
        data_out = rdreq ? data_in : PAD_VALUE;
        busy       = in_run;
        frame_done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                S_RUN: begin
                    if (wrreq) begin
                        if (col == LAST) begin
                            col <= '0;
                            if (row == LAST) state <= S_DONE;
                            else             row   <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Directed bench for featuremap_pad_writer (WIDTH=4): queue-based model of the padded frame
// order, checked every cycle, plus literal pins on timing and selected output words.
module tb_featuremap_pad_writer;

    localparam int             DW  = 32;
    localparam int             W   = 4;
    localparam logic [DW-1:0]  PAD = 32'hFFFF_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          data_fifo_empty = 1'b1;
    logic          fifo_full = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rdreq, wrreq, busy, frame_done;
    logic [DW-1:0] data_out;

    featuremap_pad_writer #(.DATA_WIDTH(DW), .WIDTH(W), .PAD_VALUE(PAD)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .data_fifo_empty(data_fifo_empty), .rdreq(rdreq), .fifo_full(fifo_full),
        .wrreq(wrreq), .data_out(data_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] up_q[$];   // upstream FIFO contents
    logic [DW-1:0] ref_q[$];  // words the model expects to see on interior positions
    logic [DW-1:0] log_q[$];  // every word written downstream
    bit            exp_pos[$]; // remaining frame positions, 1 = interior

    int n_chk = 0, n_fail = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, cyc = 0, t0 = 0;
    bit pend_pop = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endfunction

    function automatic void refresh();
        data_fifo_empty = (up_q.size() == 0);
        data_in         = data_fifo_empty ? '0 : up_q[0];
    endfunction

    function automatic void add_frame();
        for (int r = 0; r < W + 2; r++)
            for (int c = 0; c < W + 2; c++)
                exp_pos.push_back(r != 0 && r != W + 1 && c != 0 && c != W + 1);
    endfunction

    // Upstream FIFO pops take effect just after the edge that accepted them.
    always @(posedge clk) begin
        #1;
        if (pend_pop && up_q.size() > 0) void'(up_q.pop_front());
        pend_pop = 1'b0;
        refresh();
    end

    always @(negedge clk) begin
        bit            pos;
        logic [DW-1:0] e;
        if (!busy) begin
            chk("idle_wrreq", wrreq, 0);
            chk("idle_rdreq", rdreq, 0);
            chk("idle_data_out", data_out, PAD);
        end else begin
            if (fifo_full) chk("full_stall", {wrreq, rdreq}, 0);
            if (!wrreq && !fifo_full && exp_pos.size() > 0 && (!exp_pos[0] || up_q.size() > 0))
                chk("missed_write", wrreq, 1);
        end
        if (rdreq && !wrreq) chk("rd_without_wr", rdreq, 0);
        if (wrreq) begin
            if (exp_pos.size() == 0) begin
                chk("unexpected_write", wrreq, 0);
            end else begin
                pos = exp_pos.pop_front();
                e   = PAD;
                if (pos) begin
                    if (ref_q.size() > 0) e = ref_q.pop_front();
                    else fail("model_underflow");
                end
                chk("wr_data", data_out, e);
                chk("rdreq_at_pos", rdreq, pos);
            end
            log_q.push_back(data_out);
            wr_cnt++;
        end
        if (rdreq) begin
            rd_cnt++;
            if (up_q.size() == 0) fail("read_of_empty_fifo");
            pend_pop = 1'b1;
        end
        if (frame_done) begin
            done_cnt++;
            chk("done_all_written", exp_pos.size(), 0);
            chk("done_not_busy", busy, 0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic push(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            up_q.push_back(DW'(base + i));
            ref_q.push_back(DW'(base + i));
        end
        refresh();
    endtask

    task automatic start_frame();
        add_frame();
        start = 1'b1;
        cycle();
        start = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic wait_done(output int at);
        int k = 0;
        while (!frame_done && k < 400) begin
            cycle();
            k++;
        end
        if (!frame_done) fail("done_timeout");
        at = cyc - t0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int at, w0, r0, d0, l0, k;
        refresh();
        cycle();
        cycle();
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_wrreq", wrreq, 0);
        chk("rst_rdreq", rdreq, 0);
        chk("rst_data_out", data_out, PAD);
        rst = 1'b0;
        cycle();

        // Full frame, no stalls
        w0 = wr_cnt; r0 = rd_cnt; l0 = log_q.size();
        push(16, 1);
        start_frame();
        wait_done(at);
        chk("t1_done_cycle", at, 37);
        chk("t1_writes", wr_cnt - w0, 36);
        chk("t1_reads", rd_cnt - r0, 16);
        chk("t1_w0_pad", log_q[l0 + 0], PAD);
        chk("t1_w7", log_q[l0 + 7], 1);
        chk("t1_w10", log_q[l0 + 10], 4);
        chk("t1_w11_pad", log_q[l0 + 11], PAD);
        chk("t1_w13", log_q[l0 + 13], 5);
        chk("t1_w35_pad", log_q[l0 + 35], PAD);
        cycle();

        // Upstream empty until cycle 10
        w0 = wr_cnt; r0 = rd_cnt; l0 = log_q.size();
        start_frame();
        repeat (9) cycle();
        chk("t2_writes_before_data", wr_cnt - w0, 7);
        chk("t2_reads_before_data", rd_cnt - r0, 0);
        chk("t2_stalled_wrreq", wrreq, 0);
        push(16, 101);
        wait_done(at);
        chk("t2_writes", wr_cnt - w0, 36);
        chk("t2_reads", rd_cnt - r0, 16);
        chk("t2_first_interior", log_q[l0 + 7], 101);
        cycle();

        // Downstream full for 3 cycles mid-row
        w0 = wr_cnt; r0 = rd_cnt;
        push(16, 201);
        start_frame();
        repeat (7) cycle();
        fifo_full = 1'b1;
        k = wr_cnt;
        repeat (3) cycle();
        fifo_full = 1'b0;
        chk("t3_no_write_while_full", wr_cnt, k);
        wait_done(at);
        chk("t3_done_cycle", at, 40);
        chk("t3_writes", wr_cnt - w0, 36);
        chk("t3_reads", rd_cnt - r0, 16);
        cycle();

        // start ignored during RUN and during DONE
        w0 = wr_cnt; d0 = done_cnt;
        push(16, 301);
        start_frame();
        repeat (4) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(at);
        chk("t4_done_cycle", at, 37);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        chk("t4_busy_after", busy, 0);
        chk("t4_done_pulses", done_cnt - d0, 1);
        chk("t4_writes", wr_cnt - w0, 36);

        // Reset mid-frame
        w0 = wr_cnt;
        push(16, 401);
        start_frame();
        k = 0;
        while (wr_cnt - w0 < 20 && k < 100) begin
            cycle();
            k++;
        end
        rst = 1'b1;
        cycle();
        chk("t5_busy", busy, 0);
        chk("t5_wrreq", wrreq, 0);
        chk("t5_rdreq", rdreq, 0);
        chk("t5_data_out", data_out, PAD);
        chk("t5_done", frame_done, 0);
        exp_pos.delete();
        ref_q.delete();
        up_q.delete();
        refresh();
        rst = 1'b0;
        k = wr_cnt;
        repeat (3) cycle();
        chk("t5_no_write_after_rst", wr_cnt, k);
        w0 = wr_cnt; l0 = log_q.size();
        push(16, 501);
        start_frame();
        wait_done(at);
        chk("t5_restart_done_cycle", at, 37);
        chk("t5_restart_first_pad", log_q[l0], PAD);
        chk("t5_restart_first_interior", log_q[l0 + 7], 501);
        chk("t5_restart_writes", wr_cnt - w0, 36);
        cycle();

        // Back-to-back frames
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; l0 = log_q.size();
        push(32, 601);
        start_frame();
        wait_done(at);
        cycle();
        start_frame();
        wait_done(at);
        cycle();
        chk("t6_writes", wr_cnt - w0, 72);
        chk("t6_reads", rd_cnt - r0, 32);
        chk("t6_done_pulses", done_cnt - d0, 2);
        chk("t6_second_first_interior", log_q[l0 + 36 + 7], 617);
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
